// File: rtl/icache_refill_ctrl.sv
// Refill controller and arbiter that sits between two per-core instruction caches and one shared memory read port.
// Optional feature: define FILL_SHARE_EN so that one memory read fills both caches when both cores miss on the same aligned word.
module icache_refill_ctrl #(
    parameter int          WIDTH   = 8,
    parameter int          MEM_LAT = 2,
    parameter logic [31:0] NOP     = 32'h20000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_miss0,
    input  logic [WIDTH-1:0] i_adr0,
    input  logic             i_miss1,
    input  logic [WIDTH-1:0] i_adr1,
    output logic             o_mem_req,
    output logic [WIDTH-1:0] o_mem_adr,
    input  logic [31:0]      i_mem_rdata,
    output logic             o_fill0,
    output logic             o_fill1,
    output logic [WIDTH-1:0] o_fill_adr,
    output logic [31:0]      o_fill_data,
    output logic             o_stall0,
    output logic             o_stall1,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL
    } state_t;

    localparam logic [3:0]       LAT        = 4'(MEM_LAT);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_gnt;
    logic             r_lastGnt;
    logic [WIDTH-1:0] r_reqAdr;
    logic             r_memReq;
    logic [WIDTH-1:0] r_memAdr;
    logic             r_fill0;
    logic             r_fill1;
    logic [WIDTH-1:0] r_fillAdr;
    logic [31:0]      r_fillData;
    logic             r_busy;

    logic [WIDTH-1:0] w_alignAdr0;
    logic [WIDTH-1:0] w_alignAdr1;
    logic             w_anyMiss;
    logic             w_gntNext;
    logic [WIDTH-1:0] w_reqAdrNext;
    logic             w_shareHit;

    assign w_alignAdr0  = i_adr0 & ALIGN_MASK;
    assign w_alignAdr1  = i_adr1 & ALIGN_MASK;
    assign w_anyMiss    = i_miss0 | i_miss1;
    // On a tie the core that was not served last wins; otherwise the lone requester.
    assign w_gntNext    = (i_miss0 & i_miss1) ? ~r_lastGnt : i_miss1;
    assign w_reqAdrNext = w_gntNext ? w_alignAdr1 : w_alignAdr0;

`ifdef FILL_SHARE_EN
    assign w_shareHit = r_gnt ? (i_miss0 & (w_alignAdr0 == r_reqAdr))
                              : (i_miss1 & (w_alignAdr1 == r_reqAdr));
`else
    assign w_shareHit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_gnt      <= 1'b0;
            r_lastGnt  <= 1'b1;
            r_reqAdr   <= '0;
            r_memReq   <= 1'b0;
            r_memAdr   <= '0;
            r_fill0    <= 1'b0;
            r_fill1    <= 1'b0;
            r_fillAdr  <= '0;
            r_fillData <= NOP;
            r_busy     <= 1'b0;
        end else begin
            r_memReq <= 1'b0;
            r_fill0  <= 1'b0;
            r_fill1  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_anyMiss) begin
                        r_gnt    <= w_gntNext;
                        r_reqAdr <= w_reqAdrNext;
                        r_memAdr <= w_reqAdrNext;
                        r_memReq <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_cnt   <= LAT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    // A count of one means this edge closes the data-valid cycle.
                    if (r_cnt == 4'd1) begin
                        r_fillData <= i_mem_rdata;
                        r_fillAdr  <= r_reqAdr;
                        r_fill0    <= ~r_gnt | w_shareHit;
                        r_fill1    <= r_gnt | w_shareHit;
                        r_state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_lastGnt  <= r_gnt;
                    r_fillData <= NOP;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req   = r_memReq;
    assign o_mem_adr   = r_memAdr;
    assign o_fill0     = r_fill0;
    assign o_fill1     = r_fill1;
    assign o_fill_adr  = r_fillAdr;
    assign o_fill_data = r_fillData;
    assign o_busy      = r_busy;
    // A core stays stalled until its own service has drained, even if it withdrew the miss.
    assign o_stall0    = i_miss0 | (r_busy & ~r_gnt);
    assign o_stall1    = i_miss1 | (r_busy & r_gnt);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus queues expected memory requests and fills, a monitor pops and compares them.
// Extra instances with MEM_LAT of 1 and 15 check the latency range end points.
module tb_icache_refill_ctrl;

    localparam int          WIDTH   = 8;
    localparam int          MEM_LAT = 2;
    localparam logic [31:0] NOP     = 32'h20000000;
    localparam logic [31:0] JUNK    = 32'hBAADF00D;

    typedef struct {
        logic [7:0] adr;
        int         cyc;
    } reqExp_t;

    typedef struct {
        logic [1:0]  mask;
        logic [7:0]  adr;
        logic [31:0] data;
        int          cyc;
    } fillExp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        miss0, miss1;
    logic [7:0]  adr0, adr1;
    logic        memReq;
    logic [7:0]  memAdr;
    logic [31:0] memRdata;
    logic        fill0, fill1;
    logic [7:0]  fillAdr;
    logic [31:0] fillData;
    logic        stall0, stall1, busy;

    logic        latMiss;
    logic [7:0]  latAdr;
    logic [31:0] latData;
    logic        l1MemReq, l1Fill0, l1Fill1, l1Stall0, l1Stall1, l1Busy;
    logic [7:0]  l1MemAdr, l1FillAdr;
    logic [31:0] l1FillData;
    logic        l15MemReq, l15Fill0, l15Fill1, l15Stall0, l15Stall1, l15Busy;
    logic [7:0]  l15MemAdr, l15FillAdr;
    logic [31:0] l15FillData;

    int          cycleCnt = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    reqExp_t     reqQ[$];
    fillExp_t    fillQ[$];
    reqExp_t     re;
    fillExp_t    fe;
    logic [7:0]  respAdr;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    icache_refill_ctrl #(.WIDTH(WIDTH), .MEM_LAT(MEM_LAT), .NOP(NOP)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_miss0(miss0), .i_adr0(adr0), .i_miss1(miss1), .i_adr1(adr1),
        .o_mem_req(memReq), .o_mem_adr(memAdr), .i_mem_rdata(memRdata),
        .o_fill0(fill0), .o_fill1(fill1), .o_fill_adr(fillAdr), .o_fill_data(fillData),
        .o_stall0(stall0), .o_stall1(stall1), .o_busy(busy)
    );

    icache_refill_ctrl #(.WIDTH(WIDTH), .MEM_LAT(1), .NOP(NOP)) dutLat1 (
        .i_clk(clk), .i_rst_n(rstN),
        .i_miss0(latMiss), .i_adr0(latAdr), .i_miss1(1'b0), .i_adr1(8'h00),
        .o_mem_req(l1MemReq), .o_mem_adr(l1MemAdr), .i_mem_rdata(latData),
        .o_fill0(l1Fill0), .o_fill1(l1Fill1), .o_fill_adr(l1FillAdr), .o_fill_data(l1FillData),
        .o_stall0(l1Stall0), .o_stall1(l1Stall1), .o_busy(l1Busy)
    );

    icache_refill_ctrl #(.WIDTH(WIDTH), .MEM_LAT(15), .NOP(NOP)) dutLat15 (
        .i_clk(clk), .i_rst_n(rstN),
        .i_miss0(latMiss), .i_adr0(latAdr), .i_miss1(1'b0), .i_adr1(8'h00),
        .o_mem_req(l15MemReq), .o_mem_adr(l15MemAdr), .i_mem_rdata(latData),
        .o_fill0(l15Fill0), .o_fill1(l15Fill1), .o_fill_adr(l15FillAdr), .o_fill_data(l15FillData),
        .o_stall0(l15Stall0), .o_stall1(l15Stall1), .o_busy(l15Busy)
    );

    function automatic logic [31:0] memModel(input logic [7:0] a);
        if (a == 8'h2C) return 32'hDEADBEEF;
        return {16'hC0DE, a, ~a};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pushReq(input logic [7:0] a, input int c);
        reqExp_t e;
        e.adr = a;
        e.cyc = c;
        reqQ.push_back(e);
    endtask

    task automatic pushFill(input logic [1:0] m, input logic [7:0] a, input int c);
        fillExp_t e;
        e.mask = m;
        e.adr  = a;
        e.data = memModel(a);
        e.cyc  = c;
        fillQ.push_back(e);
    endtask

    // Memory: data valid exactly MEM_LAT cycles after the request cycle, junk otherwise.
    initial begin
        memRdata = JUNK;
        forever begin
            @(negedge clk);
            if (memReq) begin
                respAdr = memAdr;
                repeat (MEM_LAT) @(posedge clk);
                #1 memRdata = memModel(respAdr);
                @(posedge clk);
                #1 memRdata = JUNK;
            end
        end
    end

    // Latency instances see a word that encodes the cycle number it is valid in.
    always @(posedge clk) begin
        #1 latData = {24'hC0FFEE, cycleCnt[7:0]};
    end

    // Monitor: every request and fill pulse must match the head of its queue.
    always @(negedge clk) begin
        if (memReq) begin
            if (reqQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected mem_req: got adr %h at cycle %0d, expected none", memAdr, cycleCnt);
            end else begin
                re = reqQ.pop_front();
                checkOutput("mem_adr", memAdr, re.adr);
                checkOutput("mem_req cycle", cycleCnt, re.cyc);
            end
        end
        if (fill0 | fill1) begin
            if (fillQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected fill: got mask %b at cycle %0d, expected none", {fill1, fill0}, cycleCnt);
            end else begin
                fe = fillQ.pop_front();
                checkOutput("fill mask", {30'd0, fill1, fill0}, {30'd0, fe.mask});
                checkOutput("fill_adr", fillAdr, fe.adr);
                checkOutput("fill_data", fillData, fe.data);
                checkOutput("fill cycle", cycleCnt, fe.cyc);
            end
        end
    end

    task automatic applyReset();
        @(negedge clk);
        rstN    = 1'b0;
        miss0   = 1'b0;
        miss1   = 1'b0;
        latMiss = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset mem_req", memReq, 0);
        checkOutput("reset mem_adr", memAdr, 0);
        checkOutput("reset fills", {fill1, fill0}, 0);
        checkOutput("reset fill_adr", fillAdr, 0);
        checkOutput("reset fill_data", fillData, NOP);
        checkOutput("reset stalls", {stall1, stall0}, 0);
        rstN = 1'b1;
    endtask

    task automatic applyStimulus(input int core, input logic [7:0] a, output int t);
        @(negedge clk);
        if (core == 0) begin
            miss0 = 1'b1;
            adr0  = a;
        end else begin
            miss1 = 1'b1;
            adr1  = a;
        end
        t = cycleCnt + 1;
    endtask

    task automatic applyTie(input logic [7:0] a0, input logic [7:0] a1, output int t);
        @(negedge clk);
        miss0 = 1'b1;
        adr0  = a0;
        miss1 = 1'b1;
        adr1  = a1;
        t = cycleCnt + 1;
    endtask

    // Cores drop their miss once their fill arrives; bounded wait for the block to go idle.
    task automatic serviceWait(input int maxCycles);
        bit done = 0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            @(negedge clk);
            if (fill0) miss0 = 1'b0;
            if (fill1) miss1 = 1'b0;
            if (!miss0 && !miss1 && !busy) done = 1;
        end
        if (!done) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL service timeout: got busy=%b miss=%b%b, expected idle", busy, miss1, miss0);
        end
    endtask

    task automatic checkLatency();
        int t;
        int l1Req = -1, l1Fill = -1, l15Req = -1, l15Fill = -1;
        logic [31:0] l1Data = '0, l15Data = '0;
        logic [7:0]  l1Adr = '0, l15Adr = '0;
        @(negedge clk);
        latMiss = 1'b1;
        latAdr  = 8'h6B;
        t = cycleCnt + 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (l1MemReq && l1Req < 0) l1Req = cycleCnt;
            if (l15MemReq && l15Req < 0) l15Req = cycleCnt;
            if (l1MemReq || l15MemReq) latMiss = 1'b0;
            if (l1Fill0 && l1Fill < 0) begin
                l1Fill = cycleCnt;
                l1Data = l1FillData;
                l1Adr  = l1FillAdr;
            end
            if (l15Fill0 && l15Fill < 0) begin
                l15Fill = cycleCnt;
                l15Data = l15FillData;
                l15Adr  = l15FillAdr;
            end
        end
        checkOutput("lat1 mem_req cycle", l1Req, t);
        checkOutput("lat1 fill cycle", l1Fill, t + 2);
        checkOutput("lat1 fill_data", l1Data, {24'hC0FFEE, 8'(t + 1)});
        checkOutput("lat1 fill_adr", l1Adr, 8'h68);
        checkOutput("lat15 mem_req cycle", l15Req, t);
        checkOutput("lat15 fill cycle", l15Fill, t + 16);
        checkOutput("lat15 fill_data", l15Data, {24'hC0FFEE, 8'(t + 15)});
        checkOutput("lat15 fill_adr", l15Adr, 8'h68);
    endtask

    initial begin
        int t;
        bit reRaised;
        rstN    = 1'b0;
        miss0   = 1'b0;
        miss1   = 1'b0;
        adr0    = '0;
        adr1    = '0;
        latMiss = 1'b0;
        latAdr  = '0;
        applyReset();

        // Single core-0 miss with stall and busy tracked every cycle.
        applyStimulus(0, 8'h2D, t);
        pushReq(8'h2C, t);
        pushFill(2'b01, 8'h2C, t + MEM_LAT + 1);
        for (int i = 0; i <= MEM_LAT + 3; i++) begin
            @(negedge clk);
            checkOutput("stall0 during service", stall0, (cycleCnt <= t + MEM_LAT + 1) ? 1 : 0);
            checkOutput("busy during service", busy, (cycleCnt <= t + MEM_LAT + 1) ? 1 : 0);
            if (fill0) miss0 = 1'b0;
        end

        // Tie after reset goes to core 0, then core 0 re-misses and loses the second tie.
        applyReset();
        applyTie(8'h13, 8'h27, t);
        pushReq(8'h10, t);
        pushFill(2'b01, 8'h10, t + 3);
        pushReq(8'h24, t + 5);
        pushFill(2'b10, 8'h24, t + 8);
        pushReq(8'h80, t + 10);
        pushFill(2'b01, 8'h80, t + 13);
        reRaised = 0;
        for (int i = 0; i < 40 && (miss0 || miss1 || busy); i++) begin
            @(negedge clk);
            if (fill0 && !reRaised) begin
                adr0 = 8'h81;
                reRaised = 1;
            end else if (fill0) begin
                miss0 = 1'b0;
            end
            if (fill1) miss1 = 1'b0;
        end
        checkOutput("tie sequence idle", {busy, miss1, miss0}, 0);

        // Reset during WAIT drops the service; late memory data must not be written.
        applyStimulus(1, 8'h55, t);
        pushReq(8'h54, t);
        @(negedge clk);
        @(negedge clk);
        rstN  = 1'b0;
        miss1 = 1'b0;
        @(negedge clk);
        checkOutput("wait-reset busy", busy, 0);
        checkOutput("wait-reset mem_req", memReq, 0);
        checkOutput("wait-reset fills", {fill1, fill0}, 0);
        checkOutput("wait-reset fill_data", fillData, NOP);
        checkOutput("wait-reset stall1", stall1, 0);
        rstN = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("post-reset fill_data", fillData, NOP);

        // Core 1 withdraws its miss mid-service; the fill still lands once.
        applyStimulus(1, 8'h9E, t);
        pushReq(8'h9C, t);
        pushFill(2'b10, 8'h9C, t + 3);
        @(negedge clk);
        @(negedge clk);
        miss1 = 1'b0;
        @(negedge clk);
        checkOutput("stall1 after drop", stall1, 1);
        @(negedge clk);
        checkOutput("stall1 in fill", stall1, 1);
        @(negedge clk);
        checkOutput("stall1 after fill", stall1, 0);
        checkOutput("busy after fill", busy, 0);

        // Both cores miss on the same aligned word.
        applyTie(8'h41, 8'h43, t);
        pushReq(8'h40, t);
`ifdef FILL_SHARE_EN
        pushFill(2'b11, 8'h40, t + 3);
`else
        pushFill(2'b01, 8'h40, t + 3);
        pushReq(8'h40, t + 5);
        pushFill(2'b10, 8'h40, t + 8);
`endif
        serviceWait(40);

        checkLatency();

        repeat (5) @(negedge clk);
        checkOutput("request queue drained", reqQ.size(), 0);
        checkOutput("fill queue drained", fillQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish by %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
